rl_result_uart_packer: RTL and testbench

- Downstream stage of the RL core. Consumes the core's serial result stream (ovalid/out) and packs the bits LSB-first into bytes.
- Wraps each byte in a checksummed frame and paces the frame bytes into the existing uart_tx byte interface (uart_en pulse + uart_din).
- Carries the classification result back to the host over the same UART used for the uart_rx_control input path. uart_tx has no busy flag, so this block paces bytes itself.

---
 rtl/rl_result_uart_packer.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_rl_result_uart_packer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rl_result_uart_packer.sv
// -----------------------------------------------------------------------------
// rl_result_uart_packer
//
// Downstream stage of the RL core. Collects the core's serial result bits
// (ovalid/out) LSB-first into bytes, buffers them in a small FIFO and sends
// each byte to the host as a checksummed frame through the existing uart_tx
// byte interface. uart_tx has no busy flag, so this block paces the bytes
// itself: consecutive tx_en pulses are never closer than BYTE_GAP cycles.
//
// Frame (default build):      HEADER, data, {4'b0,len}, HEADER^data^len
// Frame (RESULT_SEQ_EN build): HEADER, seq, data, {4'b0,len},
//                              HEADER^seq^data^len
//
// Optional feature macro: RESULT_SEQ_EN
//   When defined, an 8-bit frame sequence number (reset 0, +1 per completed
//   frame, wraps 255->0) is sent after the header and folded into the
//   checksum. When undefined, frames are 4 bytes and no sequence register
//   exists.
//
// Parameters:
//   BYTE_GAP   cycles from one tx_en pulse to the next (>= 10*BAUD_CNT)
//   FIFO_DEPTH packed-byte FIFO entries; power of two, at least 2
//   HEADER     frame start byte
//
// Ports:
//   sys_clk    in   system clock
//   sys_rst    in   asynchronous active-low reset
//   ovalid     in   result bit valid, from RL core
//   out        in   result bit, from RL core
//   flush      in   one-cycle pulse; emit the partially filled byte
//   tx_en      out  one-cycle strobe to uart_tx uart_en
//   tx_data    out  byte to uart_tx uart_din; valid when tx_en=1, held after
//   overflow   out  sticky; a packed byte was dropped because the FIFO was full
//   frame_cnt  out  frames fully transmitted, wraps 65535->0
// -----------------------------------------------------------------------------
module rl_result_uart_packer #(
    parameter int unsigned BYTE_GAP   = 4400,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [7:0]  HEADER     = 8'hA5
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        ovalid,
    input  logic        out,
    input  logic        flush,
    output logic        tx_en,
    output logic [7:0]  tx_data,
    output logic        overflow,
    output logic [15:0] frame_cnt
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned GW = (BYTE_GAP > 1) ? $clog2(BYTE_GAP) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(BYTE_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
`ifdef RESULT_SEQ_EN
        S_SEQ,
`endif
        S_DATA,
        S_LEN,
        S_CHK
    } state_t;

    // -------------------------------------------------------------------------
    // Bit packer
    // -------------------------------------------------------------------------
    logic [7:0]  sreg, sreg_n;
    logic [3:0]  nbits, nbits_n;
    logic        push;
    logic [11:0] push_entry;

    // A completed byte (nbits==8) is pushed one edge after its 8th bit lands.
    // Bits arriving in that same cycle start the next byte at position 0, so a
    // continuous bit stream is never stalled. A flush in that cycle is taken
    // by the completed byte; the new bit stays pending.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // through the block can leave a value unassigned and infer a latch.
        sreg_n     = sreg;
        nbits_n    = nbits;
        push       = 1'b0;
        push_entry = 12'h000;

        if (nbits == 4'd8) begin
            push       = 1'b1;
            push_entry = {4'd8, sreg};
            sreg_n     = 8'h00;
            nbits_n    = 4'd0;
        end

        if (ovalid) begin
            sreg_n[nbits_n[2:0]] = out;
            nbits_n              = nbits_n + 4'd1;
        end

        // The bit of this cycle is included before the flush takes effect, so
        // a flush on the 8th bit yields one len=8 entry and nothing more.
        if (flush && !push && (nbits_n != 4'd0)) begin
            push       = 1'b1;
            push_entry = {nbits_n, sreg_n};
            sreg_n     = 8'h00;
            nbits_n    = 4'd0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            sreg  <= 8'h00;
            nbits <= 4'd0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            sreg  <= sreg_n;
            nbits <= nbits_n;
        end
    end

    // -------------------------------------------------------------------------
    // Packed-byte FIFO, entries {len[3:0], data[7:0]}
    // -------------------------------------------------------------------------
    logic [11:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        fifo_empty, fifo_full;
    logic        pop;
    logic        wr_ok;
    logic [11:0] head;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A pop in the same cycle frees a slot, so push+pop while full is lossless.
    assign wr_ok      = push && (!fifo_full || pop);
    assign head       = mem[rd_ptr[AW-1:0]];

    // NOTE: the storage array has no reset; only the pointers decide what is
    // valid, and leaving the array unreset lets it map onto plain RAM.
    always_ff @(posedge sys_clk) begin
        if (wr_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_entry;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            if (push && !wr_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // TX framing FSM
    // -------------------------------------------------------------------------
    state_t      state, state_n;
    logic [GW-1:0] gap_cnt;
    logic        gap_zero;
    logic [7:0]  cur_data;
    logic [3:0]  cur_len;
    logic        strobe;
    logic [7:0]  strobe_byte;
    logic        frame_done;
    logic [7:0]  chk_byte;

    assign gap_zero = (gap_cnt == '0);

`ifdef RESULT_SEQ_EN
    logic [7:0] seq;
    assign chk_byte = HEADER ^ seq ^ cur_data ^ {4'b0000, cur_len};
`else
    assign chk_byte = HEADER ^ cur_data ^ {4'b0000, cur_len};
`endif

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Each state's byte is strobed on the edge that enters that state, so the
    // state register reads the sending state during its tx_en cycle. The FSM
    // then waits there until the gap counter drains before moving on.
    always_comb begin
        state_n     = state;
        pop         = 1'b0;
        strobe      = 1'b0;
        strobe_byte = 8'h00;
        frame_done  = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (!fifo_empty && gap_zero) begin
                    pop         = 1'b1;
                    strobe      = 1'b1;
                    strobe_byte = HEADER;
                    state_n     = S_HDR;
                end
            end
            S_HDR: begin
                if (gap_zero) begin
                    strobe = 1'b1;
`ifdef RESULT_SEQ_EN
                    strobe_byte = seq;
                    state_n     = S_SEQ;
`else
                    strobe_byte = cur_data;
                    state_n     = S_DATA;
`endif
                end
            end
`ifdef RESULT_SEQ_EN
            S_SEQ: begin
                if (gap_zero) begin
                    strobe      = 1'b1;
                    strobe_byte = cur_data;
                    state_n     = S_DATA;
                end
            end
`endif
            S_DATA: begin
                if (gap_zero) begin
                    strobe      = 1'b1;
                    strobe_byte = {4'b0000, cur_len};
                    state_n     = S_LEN;
                end
            end
            S_LEN: begin
                if (gap_zero) begin
                    strobe      = 1'b1;
                    strobe_byte = chk_byte;
                    frame_done  = 1'b1;
                    state_n     = S_CHK;
                end
            end
            S_CHK: begin
                // Waiting out the gap here keeps the next HDR at least
                // BYTE_GAP cycles after the checksum byte.
                if (gap_zero) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            tx_en     <= 1'b0;
            tx_data   <= 8'h00;
            gap_cnt   <= '0;
            cur_data  <= 8'h00;
            cur_len   <= 4'd0;
            frame_cnt <= 16'd0;
        end else begin
            tx_en <= strobe;
            if (strobe) begin
                tx_data <= strobe_byte;
                gap_cnt <= GAP_LOAD;
            end else if (!gap_zero) begin
                gap_cnt <= gap_cnt - GW'(1);
            end
            if (pop) begin
                {cur_len, cur_data} <= head;
            end
            if (frame_done) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

`ifdef RESULT_SEQ_EN
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            seq <= 8'h00;
        end else if (frame_done) begin
            seq <= seq + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rl_result_uart_packer.sv
// -----------------------------------------------------------------------------
// tb_rl_result_uart_packer
//
// Self-checking bench for rl_result_uart_packer (BYTE_GAP=20, FIFO_DEPTH=4).
// A reference model turns each packed item (data, len) into the expected list
// of frame bytes; a monitor records every tx_en strobe and checks the spacing
// between strobes. Directed cases cover latency, flush handling, overflow and
// mid-frame reset; randomized bursts cover the general packing path.
// -----------------------------------------------------------------------------
module tb_rl_result_uart_packer;

    localparam int         BYTE_GAP   = 20;
    localparam int         FIFO_DEPTH = 4;
    localparam logic [7:0] HEADER     = 8'hA5;
`ifdef RESULT_SEQ_EN
    localparam int FRAME_BYTES = 5;
`else
    localparam int FRAME_BYTES = 4;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic        ovalid  = 1'b0;
    logic        out     = 1'b0;
    logic        flush   = 1'b0;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic        overflow;
    logic [15:0] frame_cnt;

    rl_result_uart_packer #(
        .BYTE_GAP   (BYTE_GAP),
        .FIFO_DEPTH (FIFO_DEPTH),
        .HEADER     (HEADER)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .ovalid    (ovalid),
        .out       (out),
        .flush     (flush),
        .tx_en     (tx_en),
        .tx_data   (tx_data),
        .overflow  (overflow),
        .frame_cnt (frame_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    always @(posedge sys_clk) cycle <= cycle + 1;

    logic [7:0] obs_q[$];
    logic [7:0] exp_q[$];
    int         exp_frames = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Strobe monitor: records bytes and checks pacing.
    int pos       = 0;
    int last_cyc  = 0;
    bit have_last = 1'b0;

    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            pos       = 0;
            have_last = 1'b0;
        end else if (tx_en) begin
            obs_q.push_back(tx_data);
            if (pos != 0)
                check("byte_gap", cycle - last_cyc, BYTE_GAP);
            else if (have_last)
                check("frame_gap_ge", ((cycle - last_cyc) >= BYTE_GAP), 1);
            last_cyc  = cycle;
            have_last = 1'b1;
            pos       = (pos + 1) % FRAME_BYTES;
        end
    end

    // Reference model: the frame the host should see for one packed item.
    task automatic model_frame(input logic [7:0] d, input int len);
        logic [7:0] l8;
        logic [7:0] sq;
        logic [7:0] chk;
        l8  = 8'(len);
        sq  = 8'(exp_frames % 256);
        chk = HEADER ^ d ^ l8;
        exp_q.push_back(HEADER);
`ifdef RESULT_SEQ_EN
        exp_q.push_back(sq);
        chk = chk ^ sq;
`endif
        exp_q.push_back(d);
        exp_q.push_back(l8);
        exp_q.push_back(chk);
        exp_frames++;
    endtask

    task automatic drive_cycle(input logic v, input logic b, input logic f);
        ovalid = v;
        out    = b;
        flush  = f;
        @(negedge sys_clk);
    endtask

    // mode 0: flush with the last bit; 1: flush one cycle later; 2: no flush
    // (len 8 only, followed by one idle cycle).
    task automatic send_item(input logic [7:0] data, input int len, input int mode,
                             input int max_gap, input bit expect_it);
        logic [7:0] masked;
        int g;
        for (int i = 0; i < len; i++) begin
            g = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
            repeat (g) drive_cycle(1'b0, 1'b0, 1'b0);
            drive_cycle(1'b1, data[i], (i == len - 1) && (mode == 0));
        end
        if (mode == 1) drive_cycle(1'b0, 1'b0, 1'b1);
        if (mode == 2) drive_cycle(1'b0, 1'b0, 1'b0);
        ovalid = 1'b0;
        out    = 1'b0;
        flush  = 1'b0;
        masked = (len >= 8) ? data : (data & 8'((1 << len) - 1));
        if (expect_it) model_frame(masked, len);
    endtask

    task automatic drain(input string tag);
        int budget;
        int waited;
        budget = exp_q.size() * (BYTE_GAP + 2) + 4 * BYTE_GAP + 100;
        waited = 0;
        while ((obs_q.size() < exp_q.size()) && (waited < budget)) begin
            @(negedge sys_clk);
            waited++;
        end
        if (obs_q.size() < exp_q.size())
            check({tag, "_timeout"}, obs_q.size(), exp_q.size());
        repeat (3 * BYTE_GAP) @(negedge sys_clk);
        check({tag, "_nbytes"}, obs_q.size(), exp_q.size());
        for (int i = 0; (i < exp_q.size()) && (i < obs_q.size()); i++)
            check($sformatf("%s_b%0d", tag, i), obs_q[i], exp_q[i]);
        check({tag, "_frame_cnt"}, frame_cnt, 32'(exp_frames % 65536));
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cycle);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        logic [7:0] ob [6];
        logic [7:0] d;
        int n;
        int len;
        int mode;
        int waited;

        // Reset state
        repeat (3) @(negedge sys_clk);
        check("rst_tx_en", tx_en, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_overflow", overflow, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        sys_rst = 1'b1;
        @(negedge sys_clk);

        // Byte 0xA5 from bits 1,0,1,0,0,1,0,1 with HDR latency check
        pat = 8'hA5;
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, pat[i], 1'b0);
        ovalid = 1'b0;
        out    = 1'b0;
        check("lat_e0", tx_en, 0);
        @(negedge sys_clk);
        check("lat_e1", tx_en, 0);
        @(negedge sys_clk);
        check("lat_e2", tx_en, 1);
        check("lat_hdr", tx_data, HEADER);
        model_frame(8'hA5, 8);
        drain("t_a5");

        // Partial byte 1,1,0 then flush; a stray flush afterwards is a no-op
        send_item(8'h03, 3, 1, 0, 1'b1);
        repeat (2) drive_cycle(1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b1);
        drive_cycle(1'b0, 1'b0, 1'b0);
        drain("t_flush3");

        // Flush coinciding with the 8th bit of 0xFF
        send_item(8'hFF, 8, 0, 0, 1'b1);
        drain("t_ff");

        // Randomized bursts that never exceed FIFO capacity
        for (int b = 0; b < 10; b++) begin
            n = $urandom_range(5, 1);
            for (int k = 0; k < n; k++) begin
                len  = $urandom_range(8, 1);
                d    = 8'($urandom);
                mode = (len == 8) ? $urandom_range(2, 0) : $urandom_range(1, 0);
                if ($urandom_range(3, 0) == 0) drive_cycle(1'b0, 1'b0, 1'b1);
                send_item(d, len, mode, 2, 1'b1);
                repeat ($urandom_range(3, 0)) drive_cycle(1'b0, 1'b0, 1'b0);
            end
            drain($sformatf("rnd%0d", b));
        end

        // Overflow: six bytes back to back, the sixth is dropped
        check("ovf_pre", overflow, 0);
        for (int k = 0; k < 6; k++) ob[k] = 8'($urandom);
        for (int k = 0; k < 6; k++)
            for (int i = 0; i < 8; i++) drive_cycle(1'b1, ob[k][i], 1'b0);
        ovalid = 1'b0;
        out    = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("ovf_set", overflow, 1);
        for (int k = 0; k < 5; k++) model_frame(ob[k], 8);
        drain("ovf");
        check("ovf_sticky", overflow, 1);

        // Reset between the DATA and LEN strobes
        send_item(8'h3C, 8, 0, 0, 1'b0);
        waited = 0;
        while ((obs_q.size() < FRAME_BYTES - 2) && (waited < 500)) begin
            @(negedge sys_clk);
            waited++;
        end
        check("mid_nbytes", obs_q.size(), FRAME_BYTES - 2);
        check("mid_data", obs_q[FRAME_BYTES - 3], 8'h3C);
        repeat (5) @(negedge sys_clk);
        #2 sys_rst = 1'b0;
        #1;
        check("arst_tx_en", tx_en, 0);
        check("arst_tx_data", tx_data, 0);
        check("arst_overflow", overflow, 0);
        check("arst_frame_cnt", frame_cnt, 0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        obs_q.delete();
        exp_q.delete();
        exp_frames = 0;
        repeat (5 * BYTE_GAP) @(negedge sys_clk);
        check("rst_no_tail", obs_q.size(), 0);

        // Fresh frames after reset (sequence restarts at 0 when enabled)
        send_item(8'h01, 8, 2, 0, 1'b1);
        send_item(8'h02, 8, 2, 0, 1'b1);
        drain("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
